// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM states and the default width.
package alu_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SHL     = 3'b001;
    localparam logic [2:0] OP_SHR     = 3'b010;
    localparam logic [2:0] OP_CNT     = 3'b011;
    localparam logic [2:0] OP_AND     = 3'b100;
    localparam logic [2:0] OP_OR      = 3'b101;
    localparam logic [2:0] OP_XOR     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op != OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the pointer,
// and the pointer moves to the other requester after each accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       ptr
);

    // One-hot grant from the current requests and pointer.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer update: after granting requester 0 point at 1, and vice versa.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            ptr <= grant[0];
        end else begin
            ptr <= ptr;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between two requesters: round-robin accept, issue, wait out the
// ALU latency, then hold the result on the winner's response handshake.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int         WIDTH    = DEF_WIDTH,
    parameter int         ALU_LAT  = 1,
    parameter logic [2:0] IDLE_SEL = 3'b100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [2:0]       req_op_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic [2:0]       req_op_1,
    output logic             resp_valid_0,
    input  logic             resp_ready_0,
    output logic [WIDTH-1:0] resp_data_0,
    output logic             resp_err_0,
    output logic             resp_valid_1,
    input  logic             resp_ready_1,
    output logic [WIDTH-1:0] resp_data_1,
    output logic             resp_err_1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(ALU_LAT - 1);

    state_t           state_r;
    logic             win_r;
    logic [CW-1:0]    wait_cnt_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [2:0]       alu_sel_r;
    logic [WIDTH-1:0] data_r;
    logic             err_r;
    logic             resp_valid_0_r;
    logic             resp_valid_1_r;

    logic [1:0]       grant_s;
    logic             ptr_s;
    logic             accept_s;
    logic             win_s;
    logic             resp_fire_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [2:0]       sel_op_s;

    // Accepts are only possible in IDLE and never while reset is held.
    assign accept_s    = reset && (state_r == ST_IDLE) && (req_valid_0 || req_valid_1);
    assign win_s       = (req_valid_0 && req_valid_1) ? ptr_s : req_valid_1;
    assign resp_fire_s = win_r ? resp_ready_1 : resp_ready_0;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     ({req_valid_1, req_valid_0}),
        .advance (accept_s),
        .grant   (grant_s),
        .ptr     (ptr_s)
    );

    assign req_ready_0  = accept_s && grant_s[0];
    assign req_ready_1  = accept_s && grant_s[1];
    assign resp_valid_0 = resp_valid_0_r;
    assign resp_valid_1 = resp_valid_1_r;
    assign resp_data_0  = data_r;
    assign resp_data_1  = data_r;
    assign resp_err_0   = err_r;
    assign resp_err_1   = err_r;
    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign alu_sel      = alu_sel_r;

    // Operand mux selecting the winning requester's operation.
    always_comb begin
        sel_a_s  = req_a_0;
        sel_b_s  = req_b_0;
        sel_op_s = req_op_0;
        if (win_s) begin
            sel_a_s  = req_a_1;
            sel_b_s  = req_b_1;
            sel_op_s = req_op_1;
        end else begin
            sel_a_s  = req_a_0;
            sel_b_s  = req_b_0;
            sel_op_s = req_op_0;
        end
    end

    // Control FSM with all ALU and response outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            win_r          <= 1'b0;
            wait_cnt_r     <= {CW{1'b0}};
            alu_a_r        <= {WIDTH{1'b0}};
            alu_b_r        <= {WIDTH{1'b0}};
            alu_sel_r      <= IDLE_SEL;
            data_r         <= {WIDTH{1'b0}};
            err_r          <= 1'b0;
            resp_valid_0_r <= 1'b0;
            resp_valid_1_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        win_r <= win_s;
                        if (op_is_legal(sel_op_s)) begin
                            state_r   <= ST_ISSUE;
                            alu_a_r   <= sel_a_s;
                            alu_b_r   <= sel_b_s;
                            alu_sel_r <= sel_op_s;
                        end else begin
                            // Illegal ops bypass the ALU entirely.
                            state_r        <= ST_RESP;
                            data_r         <= {WIDTH{1'b0}};
                            err_r          <= 1'b1;
                            resp_valid_0_r <= ~win_s;
                            resp_valid_1_r <= win_s;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_r    <= ST_WAIT;
                    wait_cnt_r <= WAIT_LOAD;
                end
                ST_WAIT: begin
                    if (wait_cnt_r == {CW{1'b0}}) begin
                        state_r        <= ST_RESP;
                        data_r         <= alu_result;
                        err_r          <= 1'b0;
                        resp_valid_0_r <= ~win_r;
                        resp_valid_1_r <= win_r;
                        alu_a_r        <= {WIDTH{1'b0}};
                        alu_b_r        <= {WIDTH{1'b0}};
                        alu_sel_r      <= IDLE_SEL;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_fire_s) begin
                        state_r        <= ST_IDLE;
                        resp_valid_0_r <= 1'b0;
                        resp_valid_1_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a clocked ALU model and a transaction-level reference.
module tb_alu_arbiter;

    localparam int         W    = 8;
    localparam int         LAT  = 1;
    localparam logic [2:0] IDLE = 3'b100;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid_0, req_ready_0, req_valid_1, req_ready_1;
    logic [W-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic [2:0]   req_op_0, req_op_1;
    logic         resp_valid_0, resp_ready_0, resp_err_0;
    logic         resp_valid_1, resp_ready_1, resp_err_1;
    logic [W-1:0] resp_data_0, resp_data_1;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_result = 8'h00;
    logic [W-1:0] alu_ctr = 8'h00;

    int   vectors = 0;
    int   miscompares = 0;
    int   rr = 0;
    int   cnt_ops = 0;
    logic pv [2];
    logic [W-1:0] pa [2];
    logic [W-1:0] pb [2];
    logic [2:0]   pop [2];
    time  last_acc = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT), .IDLE_SEL(IDLE)) dut (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_op_0(req_op_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1), .req_op_1(req_op_1),
        .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0),
        .resp_data_0(resp_data_0), .resp_err_0(resp_err_0),
        .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1),
        .resp_data_1(resp_data_1), .resp_err_1(resp_err_1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result)
    );

    // Clocked ALU with one cycle of latency; sel 011 is a counter that steps while selected.
    always @(posedge clk) begin
        case (alu_sel)
            3'b000: alu_result <= alu_a + alu_b;
            3'b001: alu_result <= alu_a << 1;
            3'b010: alu_result <= alu_a >> 1;
            3'b011: begin
                alu_ctr    <= alu_ctr + 8'd1;
                alu_result <= alu_ctr + 8'd1;
            end
            3'b100: alu_result <= alu_a & alu_b;
            3'b101: alu_result <= alu_a | alu_b;
            3'b110: alu_result <= alu_a ^ alu_b;
            default: alu_result <= 8'hEE;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rv(input int n);
        return (n == 0) ? resp_valid_0 : resp_valid_1;
    endfunction
    function automatic logic rdy(input int n);
        return (n == 0) ? req_ready_0 : req_ready_1;
    endfunction
    function automatic logic [W-1:0] rdata(input int n);
        return (n == 0) ? resp_data_0 : resp_data_1;
    endfunction
    function automatic logic rerr(input int n);
        return (n == 0) ? resp_err_0 : resp_err_1;
    endfunction

    // Expected {err, data} from the op-code table; k is the number of earlier counter ops.
    function automatic logic [8:0] ref_out(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input int k);
        int r;
        case (op)
            3'd0: r = (int'(a) + int'(b)) % 256;
            3'd1: r = (int'(a) * 2) % 256;
            3'd2: r = int'(a) / 2;
            3'd3: r = (k * (LAT + 1) + 1) % 256;
            3'd4: r = int'(a & b);
            3'd5: r = int'(a | b);
            3'd6: r = int'(a ^ b);
            default: return {1'b1, 8'h00};
        endcase
        return {1'b0, 8'(r)};
    endfunction

    task automatic drive_reqs();
        req_valid_0 = pv[0]; req_a_0 = pa[0]; req_b_0 = pb[0]; req_op_0 = pop[0];
        req_valid_1 = pv[1]; req_a_1 = pa[1]; req_b_1 = pb[1]; req_op_1 = pop[1];
    endtask

    // One full transaction for whichever requester should win; called just after a falling edge.
    task automatic one_txn(input int hold, input bit chk_space);
        int w;
        int lat;
        logic [8:0] exp;
        logic legal;
        logic [2:0] e_op;
        logic [7:0] e_a, e_b;
        drive_reqs();
        #1;
        w = (pv[0] && pv[1]) ? rr : (pv[0] ? 0 : 1);
        check_eq("ready0", req_ready_0, (w == 0));
        check_eq("ready1", req_ready_1, (w == 1));
        check_eq("sel_idle_pre", alu_sel, IDLE);
        e_op = pop[w]; e_a = pa[w]; e_b = pb[w];
        legal = (e_op != 3'b111);
        exp = ref_out(e_op, e_a, e_b, cnt_ops);
        if (e_op == 3'b011) cnt_ops++;
        @(posedge clk);
        if (chk_space) check_eq("accept_spacing", int'((($time - last_acc) / 10)), LAT + 3);
        last_acc = $time;
        pv[w] = 1'b0;
        rr = 1 - w;
        @(negedge clk);
        drive_reqs();
        for (lat = 1; lat <= 20; lat++) begin
            #1;
            if (rv(w)) break;
            check_eq("busy_sel", alu_sel, legal ? e_op : IDLE);
            check_eq("busy_ab", {alu_a, alu_b}, legal ? {e_a, e_b} : 16'h0000);
            check_eq("busy_ready", {req_ready_1, req_ready_0}, 2'b00);
            check_eq("busy_other_resp", rv(1 - w), 1'b0);
            @(negedge clk);
        end
        check_eq("latency", lat, legal ? (LAT + 2) : 1);
        check_eq("resp_data", rdata(w), exp[7:0]);
        check_eq("resp_err", rerr(w), exp[8]);
        check_eq("other_resp", rv(1 - w), 1'b0);
        check_eq("resp_sel_idle", {alu_sel, alu_a, alu_b}, {IDLE, 16'h0000});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check_eq("hold_valid", rv(w), 1'b1);
            check_eq("hold_data", {rerr(w), rdata(w)}, exp);
            check_eq("hold_ready", {req_ready_1, req_ready_0}, 2'b00);
        end
        if (w == 0) resp_ready_0 = 1'b1; else resp_ready_1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready_0 = 1'b0;
        resp_ready_1 = 1'b0;
        #1;
        check_eq("resp_drop", rv(w), 1'b0);
    endtask

    task automatic set_op(input int n, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        pv[n] = 1'b1; pop[n] = op; pa[n] = a; pb[n] = b;
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            pv[n] = 1'b0; pa[n] = 8'h00; pb[n] = 8'h00; pop[n] = 3'b000;
        end
        reset = 1'b0;
        resp_ready_0 = 1'b0;
        resp_ready_1 = 1'b0;
        drive_reqs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_ready", {req_ready_1, req_ready_0}, 2'b00);
        check_eq("rst_resp", {resp_valid_1, resp_valid_0, resp_err_0, resp_err_1}, 4'h0);
        check_eq("rst_data", {resp_data_0, resp_data_1}, 16'h0000);
        check_eq("rst_alu", {alu_sel, alu_a, alu_b}, {IDLE, 16'h0000});
        reset = 1'b1;

        // Simultaneous pair straight after reset, then a lone op, then a second pair.
        set_op(0, 3'b001, 8'h05, 8'h00);
        set_op(1, 3'b010, 8'h05, 8'h00);
        one_txn(0, 1'b0);
        one_txn(0, 1'b0);
        set_op(0, 3'b000, 8'h05, 8'h03);
        one_txn(0, 1'b0);
        set_op(0, 3'b001, 8'h05, 8'h00);
        set_op(1, 3'b010, 8'h05, 8'h00);
        check_eq("pair2_ptr", rr, 1);
        one_txn(1, 1'b0);
        one_txn(0, 1'b0);

        set_op(1, 3'b111, 8'h12, 8'h34);
        one_txn(2, 1'b0);
        set_op(0, 3'b000, 8'hFF, 8'h01);
        one_txn(5, 1'b0);

        // Reset while the op is in WAIT: it must vanish without a response.
        set_op(0, 3'b000, 8'h11, 8'h22);
        drive_reqs();
        #1;
        check_eq("rst_op_ready", req_ready_0, 1'b1);
        @(posedge clk);
        pv[0] = 1'b0;
        @(negedge clk);
        drive_reqs();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        rr = 0;
        #1;
        check_eq("midrst_resp", {resp_valid_1, resp_valid_0}, 2'b00);
        check_eq("midrst_alu", {alu_sel, alu_a, alu_b}, {IDLE, 16'h0000});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check_eq("midrst_no_resp", {resp_valid_1, resp_valid_0}, 2'b00);
        end
        set_op(0, 3'b000, 8'h05, 8'h03);
        one_txn(0, 1'b0);

        // Back-to-back AND/OR/XOR with the response consumed immediately.
        for (int i = 0; i < 3; i++) begin
            set_op(0, 3'(4 + i), 8'h05, 8'h03);
            one_txn(0, (i > 0));
        end

        for (int it = 0; it < 150; it++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pv[n] && ($urandom_range(0, 1) == 1)) begin
                    set_op(n, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                end
            end
            if (!pv[0] && !pv[1]) begin
                set_op(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            end
            one_txn(int'($urandom_range(0, 3)), 1'b0);
        end
        while (pv[0] || pv[1]) one_txn(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single clocked 8-bit ALU between two requesters, requester 0 and requester 1.

- Each requester submits one operation (A, B, op) over a valid/ready handshake.
- The block picks a winner by round-robin, drives the ALU select and operands, and waits out the ALU's registered latency.
- It returns the result, with an error flag, on a per-requester response handshake.
- It sits between the ALU and its clients and is the only block that drives the ALU's A, B and sel inputs.

## Interface
- WIDTH, 8: operand/result width.
- ALU_LAT, 1: ALU clock edges from sel/A/B valid to Result valid (≥1).
- IDLE_SEL, 3'b100: sel driven when no op is in flight (side-effect free; never 3'b011).

Ports (n = 0, 1):
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low.
- req_valid_n  in  1  requester n has an op.
- req_ready_n  out  1  op accepted this cycle (valid & ready).
- req_a_n, req_b_n  in  WIDTH  operands.
- req_op_n  in  3  op code.
- resp_valid_n  out  1  response pending for requester n.
- resp_ready_n  in  1  requester n consumes response.
- resp_data_n  out  WIDTH  result.
- resp_err_n  out  1  illegal op.
- alu_a, alu_b  out  WIDTH  to ALU A/B.
- alu_sel  out  3  to ALU sel.
- alu_result  in  WIDTH  from ALU Result.

## Operation
- Op codes:
  - 000 add (mod 2^WIDTH)
  - 001 shift-left A by 1
  - 010 shift-right A by 1
  - 011 ALU counter (result passed through uninterpreted)
  - 100 AND, 101 OR, 110 XOR
  - 111 illegal
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is asserted combinationally for exactly the granted requester when any req_valid is high.
  - A, B, op and the winner index are latched on that edge.
  - Next state: ISSUE for a legal op; RESP for op 111.
- ISSUE (1 cycle): alu_a/alu_b/alu_sel are driven from the latches. Next state: WAIT.
- WAIT (ALU_LAT cycles):
  - ALU inputs are held.
  - alu_result is sampled into resp_data on the last WAIT edge, and resp_err is set to 0.
  - Next state: RESP.
- RESP:
  - resp_valid of the winner is high; the other requester's resp_valid is 0.
  - resp_data/resp_err stay stable until resp_ready.
  - On resp_valid & resp_ready, the next state is IDLE.
- Illegal op: resp_data=0, resp_err=1, and the ALU is never driven with it.
- Outside ISSUE/WAIT: alu_sel=IDLE_SEL, alu_a=alu_b=0.
- Round-robin:
  - The priority pointer resets to 0.
  - On both valid in the same IDLE cycle, the pointer's requester wins.
  - After every grant, the pointer moves to the other requester.
  - A lone requester always wins regardless of the pointer.
- A requester must hold req_valid and its operands stable until ready. The losing requester simply waits.
- Only one op is in flight at a time. req_ready is 0 in ISSUE/WAIT/RESP.

## Timing
- Reset (reset=0 at an edge), taking effect the next cycle:
  - State IDLE, pointer 0.
  - req_ready_0/1=0 (until IDLE grant logic runs), resp_valid_0/1=0, resp_data=0, resp_err=0.
  - alu_sel=IDLE_SEL, alu_a=alu_b=0.
- Reset mid-operation (any state) drops the in-flight op. No response is ever produced for it.
- Legal op, accepted at cycle T:
  - ISSUE at T+1.
  - WAIT for T+2 … T+1+ALU_LAT.
  - resp_valid at T+2+ALU_LAT. With ALU_LAT=1 this is T+3.
- Illegal op accepted at T: resp_valid at T+1.
- Response consumed at cycle R: IDLE at R+1, and the next accept is possible at R+1.
- Peak throughput is one legal op per ALU_LAT+3 cycles with resp_ready tied high.
- A valid asserted during RESP is not accepted before the cycle after the handshake.

## Structure
- Package alu_pkg holds:
  - op-code constants (OP_ADD … OP_XOR, OP_ILLEGAL=3'b111)
  - the FSM state enum
  - WIDTH default
- Sub-module rr_arb2:
  - Inputs: req[1:0], advance.
  - Outputs: one-hot grant[1:0], the pointer register.
  - Uses the same clk/reset.
- The datapath latches, FSM and WAIT counter (width clog2(ALU_LAT+1)) live in alu_arbiter.

## Test plan
- Req0 A=0x05 B=0x03 op=000, ALU_LAT=1, resp_ready=1 → req_ready_0 at T, alu_sel=000 at T+1, resp_valid_0 at T+3 with data 0x08, err 0.
- Both valid at once: req0 op=001 A=0x05, req1 op=010 A=0x05.
  - First after reset, req0 gets 0x0A.
  - Then req1 gets 0x02.
  - Second pair: req1 is served first.
- Req1 op=111 → resp_valid_1 at T+1, data 0x00, err 1; alu_sel stays IDLE_SEL throughout.
- Req0 A=0xFF B=0x01 op=000 with resp_ready_0=0 for 5 cycles:
  - resp_data_0=0x00 is held stable and req_ready stays 0.
  - Release → IDLE next cycle.
- reset=0 during WAIT → next cycle resp_valid_0/1=0 and alu_sel=IDLE_SEL; no response ever appears; the next op after release completes normally.
- Back-to-back AND/OR/XOR on A=0x05 B=0x03 → 0x01, 0x07, 0x06; accept spacing is exactly ALU_LAT+3 cycles.
